// File: rtl/pipe_muldiv.sv
// pipe_muldiv: iterative MIPS mult/multu/div/divu/mthi/mtlo unit owning HI/LO; stalls EX while busy.
// Optional MULDIV_EARLY_OUT_EN: a divide whose divisor magnitude exceeds the dividend's finishes in two cycles.
module pipe_muldiv #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MUL_LATENCY = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int unsigned CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
   localparam int unsigned CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic [WIDTH-1:0]  opa, opa_nx;
   logic [WIDTH-1:0]  opb, opb_nx;
   logic [WIDTH-1:0]  rem, rem_nx;
   logic [WIDTH-1:0]  quo, quo_nx;
   logic              sgn, sgn_nx;
   logic              qneg, qneg_nx;
   logic              rneg, rneg_nx;
   logic [WIDTH-1:0]  hi_nx, lo_nx;
   logic              step_en;

`ifdef MULDIV_EARLY_OUT_EN
   logic              early, early_nx;
   assign step_en = ~early;
`else
   assign step_en = 1'b1;
`endif

   // Operand magnitudes and signs for a divide issued this cycle
   logic              a_neg, b_neg;
   logic [WIDTH-1:0]  a_mag, b_mag;
   always_comb begin
      a_neg = (op == OP_DIV) & a[WIDTH-1];
      b_neg = (op == OP_DIV) & b[WIDTH-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
   end

   // Full-width product; sign extension to 2*WIDTH makes the truncated product exact for both signednesses
   logic [2*WIDTH-1:0] ext_a, ext_b, prod;
   always_comb begin
      ext_a = sgn ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
      ext_b = sgn ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
      prod  = ext_a * ext_b;
   end

   // One restoring-division step: shift in the next dividend bit, subtract if it fits
   logic [WIDTH:0]   sh;
   logic             ge;
   logic [WIDTH-1:0] diff;
   always_comb begin
      sh   = {rem, quo[WIDTH-1]};
      ge   = (sh >= {1'b0, opb});
      diff = sh[WIDTH-1:0] - opb;
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      opa_nx   = opa;
      opb_nx   = opb;
      rem_nx   = rem;
      quo_nx   = quo;
      sgn_nx   = sgn;
      qneg_nx  = qneg;
      rneg_nx  = rneg;
      hi_nx    = hi;
      lo_nx    = lo;
      done     = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      early_nx = early;
`endif
      case (state)
         IDLE: begin
            if (start && !cancel) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     opa_nx   = a;
                     opb_nx   = b;
                     sgn_nx   = (op == OP_MULT);
                     cnt_nx   = CW'(MUL_LATENCY - 1);
                     state_nx = MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     opb_nx   = b_mag;
                     rem_nx   = '0;
                     quo_nx   = a_mag;
                     // divide by zero keeps the all-ones quotient regardless of sign
                     qneg_nx  = (a_neg ^ b_neg) && (b != '0);
                     rneg_nx  = a_neg;
                     cnt_nx   = CW'(WIDTH - 1);
                     state_nx = DIV;
`ifdef MULDIV_EARLY_OUT_EN
                     early_nx = 1'b0;
                     if (b_mag > a_mag) begin
                        rem_nx   = a_mag;
                        quo_nx   = '0;
                        cnt_nx   = '0;
                        early_nx = 1'b1;
                     end
`endif
                  end
                  OP_MTHI: hi_nx = a;
                  OP_MTLO: lo_nx = a;
                  default: ;
               endcase
            end
         end
         MUL: begin
            if (cancel) begin
               state_nx = IDLE;
            end else if (cnt == '0) begin
               {hi_nx, lo_nx} = prod;
               done           = 1'b1;
               state_nx       = IDLE;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         DIV: begin
            if (cancel) begin
               state_nx = IDLE;
            end else begin
               if (step_en) begin
                  rem_nx = ge ? diff : sh[WIDTH-1:0];
                  quo_nx = {quo[WIDTH-2:0], ge};
               end
               if (cnt == '0) state_nx = FIX;
               else           cnt_nx   = cnt - CW'(1);
            end
         end
         FIX: begin
            if (cancel) begin
               state_nx = IDLE;
            end else begin
               lo_nx    = qneg ? -quo : quo;
               hi_nx    = rneg ? -rem : rem;
               done     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         opa   <= '0;
         opb   <= '0;
         rem   <= '0;
         quo   <= '0;
         sgn   <= 1'b0;
         qneg  <= 1'b0;
         rneg  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         busy  <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
         early <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         opa   <= opa_nx;
         opb   <= opb_nx;
         rem   <= rem_nx;
         quo   <= quo_nx;
         sgn   <= sgn_nx;
         qneg  <= qneg_nx;
         rneg  <= rneg_nx;
         hi    <= hi_nx;
         lo    <= lo_nx;
         busy  <= (state_nx != IDLE);
`ifdef MULDIV_EARLY_OUT_EN
         early <= early_nx;
`endif
      end
   end
endmodule

// File: tb/tb_pipe_muldiv.sv
// Testbench for pipe_muldiv: directed and random operations checked against an arithmetic model of HI/LO.
module tb_pipe_muldiv;
   localparam int unsigned W  = 32;
   localparam int          ML = 4;
`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic          clock, reset, start, cancel;
   logic [2:0]    op;
   logic [W-1:0]  a, b;
   logic          busy, done;
   logic [W-1:0]  hi, lo;

   int            tests, fails;
   logic [31:0]   m_hi, m_lo;

   pipe_muldiv #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: MIPS semantics from plain 64-bit arithmetic; returns expected busy length (0 = no busy)
   task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
      longint sx, sy, ax, ay, q, r;
      longint unsigned ux, uy;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'h0, x};
      uy = {32'h0, y};
      lat = 0;
      case (o)
         3'd0: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; lat = ML; end
         3'd1: begin p = ux * uy; m_hi = p[63:32]; m_lo = p[31:0]; lat = ML; end
         3'd2: begin
            ax = (sx < 0) ? -sx : sx;
            ay = (sy < 0) ? -sy : sy;
            if (y == 32'h0) begin
               m_lo = 32'hFFFF_FFFF; m_hi = x;
            end else begin
               q = sx / sy; r = sx % sy;
               p = q; m_lo = p[31:0];
               p = r; m_hi = p[31:0];
            end
            lat = (EARLY && ay > ax) ? 2 : W + 1;
         end
         3'd3: begin
            if (y == 32'h0) begin
               m_lo = 32'hFFFF_FFFF; m_hi = x;
            end else begin
               p = ux / uy; m_lo = p[31:0];
               p = ux % uy; m_hi = p[31:0];
            end
            lat = (EARLY && uy > ux) ? 2 : W + 1;
         end
         3'd4: m_hi = x;
         3'd5: m_lo = x;
         default: ;
      endcase
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      int lat, cyc;
      bit got;
      model(o, x, y, lat);
      @(negedge clock);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clock);
      start = 1'b0;
      if (lat == 0) begin
         chk({tag, ".busy"}, busy, 0);
         chk({tag, ".done"}, done, 0);
      end else begin
         chk({tag, ".busy1"}, busy, 1);
         cyc = 1; got = 1'b0;
         while (!got && cyc <= 100) begin
            if (done) got = 1'b1;
            else begin
               @(negedge clock);
               cyc++;
            end
         end
         chk({tag, ".lat"}, cyc, lat);
         chk({tag, ".busy_at_done"}, busy, 1);
         @(negedge clock);
         chk({tag, ".busy_after"}, busy, 0);
         chk({tag, ".done_pulse"}, done, 0);
      end
      chk({tag, ".hi"}, hi, m_hi);
      chk({tag, ".lo"}, lo, m_lo);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] rx, ry;
      bit          seen;
      tests = 0; fails = 0;
      m_hi = '0; m_lo = '0;
      reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(negedge clock);
      chk("reset.hi", hi, 0);
      chk("reset.lo", lo, 0);
      chk("reset.busy", busy, 0);
      chk("reset.done", done, 0);
      reset = 1'b0;

      // Directed vectors
      run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3);
      chk("mult.hi_k", hi, 32'hFFFF_FFFF);
      chk("mult.lo_k", lo, 32'hFFFF_FFFA);
      run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3);
      chk("multu.hi_k", hi, 32'h0000_0002);
      run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
      chk("div_neg.lo_k", lo, 32'hFFFF_FFFD);
      chk("div_neg.hi_k", hi, 32'hFFFF_FFFF);
      run_op("divu", 3'd3, 32'd100, 32'd7);
      chk("divu.lo_k", lo, 32'd14);
      run_op("div0", 3'd2, 32'd5, 32'd0);
      chk("div0.lo_k", lo, 32'hFFFF_FFFF);
      run_op("div0_neg", 3'd2, 32'hFFFF_FF00, 32'd0);
      run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf.lo_k", lo, 32'h8000_0000);
      run_op("divu_small", 3'd3, 32'd3, 32'd10);
      chk("divu_small.hi_k", hi, 32'd3);
      run_op("div_small_neg", 3'd2, 32'hFFFF_FFFD, 32'd10);
      run_op("unused6", 3'd6, 32'hDEAD_BEEF, 32'd1);
      run_op("mthi", 3'd4, 32'h0000_1234, 32'd0);
      run_op("mtlo", 3'd5, 32'h0000_5678, 32'd0);

      // Cancel on cycle 5 of a divide
      @(negedge clock);
      start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      @(negedge clock);
      chk("cancel.busy_c5", busy, 1);
      cancel = 1'b1;
      @(negedge clock);
      cancel = 1'b0;
      chk("cancel.busy_drop", busy, 0);
      seen = 1'b0;
      repeat (40) begin
         if (done) seen = 1'b1;
         @(negedge clock);
      end
      chk("cancel.no_done", seen, 0);
      chk("cancel.hi", hi, 32'h0000_1234);
      chk("cancel.lo", lo, 32'h0000_5678);

      // Start together with cancel in IDLE is ignored
      @(negedge clock);
      start = 1'b1; cancel = 1'b1; op = 3'd4; a = 32'hFFFF_0000;
      @(negedge clock);
      op = 3'd2; a = 32'd50; b = 32'd5;
      @(negedge clock);
      start = 1'b0; cancel = 1'b0;
      chk("startcancel.busy", busy, 0);
      chk("startcancel.hi", hi, m_hi);
      chk("startcancel.lo", lo, m_lo);

      // Random operations
      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 7));
         rx = $urandom;
         ry = $urandom;
         if ($urandom_range(0, 3) == 0) rx = $urandom_range(0, 20);
         if ($urandom_range(0, 3) == 0) ry = 32'($signed(-$urandom_range(0, 9)));
         if ($urandom_range(0, 9) == 0) ry = 32'h0;
         run_op("rnd", ro, rx, ry);
      end

      // Reset in the middle of a divide, asserted between clock edges
      run_op("pre_mthi", 3'd4, 32'hAAAA_5555, 32'd0);
      run_op("pre_mtlo", 3'd5, 32'h5555_AAAA, 32'd0);
      @(negedge clock);
      start = 1'b1; op = 3'd2; a = 32'd123456; b = 32'd7;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      #3 reset = 1'b1;
      #1;
      chk("midreset.hi", hi, 0);
      chk("midreset.lo", lo, 0);
      chk("midreset.busy", busy, 0);
      chk("midreset.done", done, 0);
      m_hi = '0; m_lo = '0;
      @(negedge clock);
      reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         if (done || busy) seen = 1'b1;
         @(negedge clock);
      end
      chk("midreset.quiet", seen, 0);
      run_op("post_reset_mult", 3'd0, 32'h8000_0000, 32'h8000_0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
